// File: rtl/sobel_window_fetcher_if.sv
// Window-fetcher bus: frame control, BRAM read port and the window valid/ready output.
interface sobel_window_fetcher_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
);
  logic                start;
  logic                busy;
  logic                done;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                win_valid;
  logic                win_ready;
  logic [10:0]         win_x;
  logic [10:0]         win_y;
  logic [9*DATA_W-1:0] win_data;

  modport master (
    input  start, rd_data, win_ready,
    output busy, done, rd_en, rd_addr, win_valid, win_x, win_y, win_data
  );

  modport slave (
    output start, rd_data, win_ready,
    input  busy, done, rd_en, rd_addr, win_valid, win_x, win_y, win_data
  );
endinterface

// File: rtl/sobel_window_fetcher.sv
// Raster-order 3x3 window reader: nine BRAM reads per centre pixel, zero padding at
// frame edges, window presented on valid/ready.
module sobel_window_fetcher #(
  parameter int H_RES  = 512,
  parameter int V_RES  = 384,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 18
) (
  input logic                   clk,
  input logic                   reset,
  sobel_window_fetcher_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, LAST, OUT, DONE} state_t;

  localparam logic signed [11:0] H_LIM  = 12'(H_RES);
  localparam logic signed [11:0] V_LIM  = 12'(V_RES);
  localparam logic [10:0]        X_LAST = 11'(H_RES - 1);
  localparam logic [10:0]        Y_LAST = 11'(V_RES - 1);

  state_t                  state;
  logic [10:0]             x, y;
  logic [3:0]              k;
  logic                    pad_prev;
  logic [8:0][DATA_W-1:0]  win_q;
  logic                    busy_q, done_q, vld_q;

  logic [1:0]              kc, kr;
  logic signed [11:0]      nx, ny;
  logic                    in_range;
  logic [ADDR_W-1:0]       addr;
  logic [3:0]              cap_idx;
  logic [DATA_W-1:0]       cap_val;

  // Neighbour offset from slot index: column = k mod 3, row = k div 3.
  always_comb begin
    kc = k[1:0];
    kr = 2'd0;
    if (k >= 4'd6) begin
      kr = 2'd2;
      kc = 2'(k - 4'd6);
    end else if (k >= 4'd3) begin
      kr = 2'd1;
      kc = 2'(k - 4'd3);
    end
    nx       = $signed({1'b0, x}) + $signed({10'd0, kc}) - 12'sd1;
    ny       = $signed({1'b0, y}) + $signed({10'd0, kr}) - 12'sd1;
    in_range = (nx >= 12'sd0) && (nx < H_LIM) && (ny >= 12'sd0) && (ny < V_LIM);
    addr     = ADDR_W'(nx[10:0]) + ADDR_W'(ny[10:0]) * ADDR_W'(H_RES);
    cap_idx  = (state == LAST) ? 4'd8 : 4'(k - 4'd1);
    cap_val  = pad_prev ? '0 : bus.rd_data;
  end

  // Read port is a pure decode of registered state; no path from win_ready.
  assign bus.rd_en     = (state == FETCH) && in_range;
  assign bus.rd_addr   = bus.rd_en ? addr : '0;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.win_valid = vld_q;
  assign bus.win_x     = x;
  assign bus.win_y     = y;
  assign bus.win_data  = win_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      k        <= '0;
      pad_prev <= 1'b0;
      win_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          x      <= '0;
          y      <= '0;
          k      <= '0;
          busy_q <= 1'b1;
          state  <= FETCH;
        end
        FETCH: begin
          // Data returned this cycle belongs to the slot issued last cycle.
          if (k != 4'd0) win_q[cap_idx] <= cap_val;
          pad_prev <= !in_range;
          if (k == 4'd8) state <= LAST;
          else           k     <= k + 4'd1;
        end
        LAST: begin
          win_q[cap_idx] <= cap_val;
          vld_q          <= 1'b1;
          state          <= OUT;
        end
        OUT: if (bus.win_ready) begin
          vld_q <= 1'b0;
          if (x == X_LAST && y == Y_LAST) begin
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            if (x == X_LAST) begin
              x <= '0;
              y <= y + 11'd1;
            end else begin
              x <= x + 11'd1;
            end
            k     <= '0;
            state <= FETCH;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_window_fetcher.sv
// Cycle-stepped bench for the window fetcher on a 4x3 frame with BRAM data = addr+1.
module tb_sobel_window_fetcher;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int DW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_window_fetcher_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  sobel_window_fetcher #(.H_RES(H), .V_RES(V), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // BRAM: 1-cycle latency, junk when not enabled so padding must really substitute 0.
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? (DW'(bus.rd_addr) + 8'd1) : 8'($urandom);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: neighbour of (x,y) for slot s and whether it lies in the frame.
  function automatic bit ref_in(input int x, input int y, input int s);
    int nx = x + (s % 3) - 1;
    int ny = y + (s / 3) - 1;
    return (nx >= 0) && (nx < H) && (ny >= 0) && (ny < V);
  endfunction

  function automatic int ref_addr(input int x, input int y, input int s);
    return (x + (s % 3) - 1) + (y + (s / 3) - 1) * H;
  endfunction

  function automatic logic [71:0] ref_win(input int x, input int y);
    logic [71:0] r = '0;
    for (int s = 0; s < 9; s++)
      if (ref_in(x, y, s)) r[s*8 +: 8] = 8'(ref_addr(x, y, s) + 1);
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  bus.busy,      1'b0);
    chk({tag, "_done"},  bus.done,      1'b0);
    chk({tag, "_rden"},  bus.rd_en,     1'b0);
    chk({tag, "_valid"}, bus.win_valid, 1'b0);
    chk({tag, "_addr"},  bus.rd_addr,   '0);
    chk({tag, "_x"},     bus.win_x,     '0);
    chk({tag, "_y"},     bus.win_y,     '0);
    chk({tag, "_data"},  bus.win_data,  '0);
  endtask

  // mode 0: ready always 1; mode 1: 5-cycle stall on window (1,0) plus a start
  // pulse while busy; mode 2: random stalls and random ready outside OUT.
  // abort_w >= 0 applies reset during that window's FETCH.
  task automatic run_frame(input int mode, input int abort_w);
    int cyc = 0;
    int stall_total = 0;
    int stalls;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    for (int w = 0; w < H * V; w++) begin
      int x = w % H;
      int y = w / H;
      for (int s = 0; s < 9; s++) begin
        if (w == abort_w && s == 3) begin
          reset = 1'b1;
          @(negedge clk);
          chk_reset_vals("abort");
          reset = 1'b0;
          @(negedge clk);
          chk_reset_vals("abort_idle");
          return;
        end
        chk("f_busy",  bus.busy,      1'b1);
        chk("f_valid", bus.win_valid, 1'b0);
        chk("f_rden",  bus.rd_en,     ref_in(x, y, s));
        chk("f_addr",  bus.rd_addr,   ref_in(x, y, s) ? 72'(ref_addr(x, y, s)) : 72'd0);
        bus.win_ready = (mode == 2) ? 1'($urandom) : 1'b1;
        @(negedge clk);
        cyc++;
      end
      chk("l_valid", bus.win_valid, 1'b0);
      chk("l_rden",  bus.rd_en,     1'b0);
      bus.win_ready = (mode == 2) ? 1'($urandom) : 1'b1;
      @(negedge clk);
      cyc++;
      stalls = (mode == 1) ? ((w == 1) ? 5 : 0) : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      stall_total += stalls;
      for (int i = 0; i <= stalls; i++) begin
        chk("o_valid", bus.win_valid, 1'b1);
        chk("o_rden",  bus.rd_en,     1'b0);
        chk("o_x",     bus.win_x,     72'(x));
        chk("o_y",     bus.win_y,     72'(y));
        chk("o_data",  bus.win_data,  ref_win(x, y));
        bus.win_ready = (i == stalls);
        bus.start     = (mode == 1 && i == 2);
        @(negedge clk);
        cyc++;
      end
      bus.start = 1'b0;
    end
    bus.win_ready = 1'b1;
    chk("done_pulse", bus.done, 1'b1);
    chk("done_busy",  bus.busy, 1'b1);
    chk("done_cyc",   72'(cyc), 72'(H * V * 11 + 1 + stall_total));
    @(negedge clk);
    chk("post_done",  bus.done,      1'b0);
    chk("post_busy",  bus.busy,      1'b0);
    chk("post_valid", bus.win_valid, 1'b0);
    repeat (2) @(negedge clk);
    chk("idle_busy", bus.busy,  1'b0);
    chk("idle_rden", bus.rd_en, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.win_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_reset_vals("idle");
    end
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(0, 5);
    run_frame(0, -1);
    repeat (3) run_frame(2, -1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sobel_window_fetcher.md
# sobel_window_fetcher

Sequential reader for the Sobel datapath. On `start`, it walks a frame buffer in raster order. For each centre pixel it issues the nine 3x3-neighbourhood reads to a single-port BRAM with 1-cycle read latency, and assembles the window. Out-of-frame neighbours are zero-padded by substituting data 0 directly; address 0 is never read as a stand-in. Each completed window is presented with its centre coordinate on a valid/ready interface to the downstream Sobel kernel.

## Interface
- `H_RES`, 512, frame width in pixels
- `V_RES`, 384, frame height in pixels
- `DATA_W`, 8, pixel width
- `ADDR_W`, 18, BRAM address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a frame scan; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last window handshake
- `rd_en`  out  1  BRAM read enable
- `rd_addr`  out  ADDR_W  BRAM address, x + y*H_RES
- `rd_data`  in  DATA_W  BRAM data, valid the cycle after `rd_en`
- `win_valid`  out  1  window available
- `win_ready`  in  1  downstream accepts window
- `win_x`, `win_y`  out  11 each  centre coordinate of the current window
- `win_data`  out  9*DATA_W  slots 0..8 = TL,TC,TR,CL,C,CR,BL,BC,BR; slot 0 in the LSBs

## Operation
- States: IDLE, FETCH, LAST, OUT, DONE.
- IDLE: when `start`=1, clear x,y and k, then go to FETCH. `start` in any other state is ignored.
- FETCH: k counts 0..8; slot k is issued this cycle.
  - Neighbour offset is dx = (k mod 3) - 1, dy = (k div 3) - 1.
  - In range (0 ≤ x+dx < H_RES and 0 ≤ y+dy < V_RES): `rd_en`=1, `rd_addr` = (x+dx) + (y+dy)*H_RES, computed at full ADDR_W width with no truncation.
  - Out of range: `rd_en`=0, `rd_addr`=0, and the slot is marked pad.
  - After k=8, go to LAST.
- Capture: slot k-1 is written on each FETCH cycle with k ≥ 1, and slot 8 is written in LAST. The written value is `rd_data`, or 0 if that slot was marked pad.
- LAST: go to OUT.
- OUT: `win_valid`=1. `win_data`, `win_x`, `win_y` are held stable while `win_ready`=0. On `win_valid`&&`win_ready`:
  - if (x,y) = (H_RES-1, V_RES-1), go to DONE;
  - otherwise increment x, wrapping to 0 and incrementing y, then go to FETCH with k=0.
- DONE: `done`=1 for one cycle, then go to IDLE.
- No BRAM reads occur outside FETCH.
- Reset values: state IDLE; `busy`, `done`, `rd_en`, `win_valid` = 0; `rd_addr`, `win_x`, `win_y`, `win_data` = 0.
- Reset mid-scan: the next cycle is IDLE with all outputs at reset values. No partial window is emitted, and the scan does not resume.

## Timing
- `start` sampled at edge T. FETCH occupies cycles T+1..T+9 and LAST is T+10. `win_valid` first rises at T+11.
- Per-window throughput with `win_ready` held 1: 11 cycles (9 FETCH, 1 LAST, 1 OUT).
- A full frame takes H_RES*V_RES*11 cycles. `done` is asserted the cycle after the final handshake.
- `rd_en`/`rd_addr` are decoded from registered state, x, y and k. They are glitch-free relative to `clk` and carry no combinational path from `win_ready`.
- Backpressure stalls only in OUT; stall cycles add directly to latency.

## Test plan
Bench configuration for all scenarios: H_RES=4, V_RES=3, DATA_W=8. BRAM model returns data = addr+1, so pad 0 is distinguishable from pixel data.
- Reset hold, then release with no `start` -> all outputs 0, state IDLE, `busy`=0 indefinitely.
- `start` at T, `win_ready`=1 -> first `win_valid` at T+11 with (x,y)=(0,0) and slots = {0,0,0,0,1,2,0,5,6}. `rd_en`=0 in slots 0,1,2,3,6.
- Window (1,1) -> slots {1,2,3,5,6,7,9,10,11}, with all nine reads issued at addresses 0,1,2,4,5,6,8,9,10.
- Window (3,2) -> slots {7,8,0,11,12,0,0,0,0}. `rd_en` low in slots 2,5,6,7,8, and `rd_addr` never exceeds 11.
- Backpressure: hold `win_ready`=0 for 5 cycles on window (1,0) -> `win_data`/`win_x`/`win_y` stable, `rd_en`=0 throughout, next FETCH begins the cycle after the handshake; pulse `start` while busy -> no effect.
- Full frame with `win_ready`=1 -> 12 windows in raster order, `done` pulse exactly 132 cycles after `start`'s edge plus 1, `busy` falls with IDLE. Separately, assert `reset` during window 5 FETCH -> IDLE next cycle, all outputs 0, a new `start` restarts at (0,0).
